// File: rtl/uart_rx_ctrl.sv
// Receive-path controller: gates the rx engine enable, forwards received bytes to the
// rx FIFO, keeps sticky overrun/frame-error flags and generates threshold/timeout IRQs.
module uart_rx_ctrl #(
   parameter int OSR         = 16,
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CHR = 4,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          rx_enable_i,
   input  logic          osr_tick_i,
   output logic          rx_en_o,
   input  logic          eng_busy_i,
   input  logic          eng_wen_i,
   input  logic [7:0]    eng_data_i,
   output logic          fifo_wen_o,
   output logic [7:0]    fifo_wdata_o,
   input  logic          fifo_full_i,
   input  logic [CW-1:0] fifo_count_i,
   input  logic [CW-1:0] rx_thresh_i,
   output logic          irq_thresh_o,
   output logic          irq_timeout_o,
   input  logic          timeout_clr_i,
   output logic          overrun_o,
   output logic          frame_err_o,
   input  logic          err_clr_i,
   output logic [15:0]   frame_cnt_o
);

   localparam int            LIMIT    = TIMEOUT_CHR * 10 * OSR;
   localparam int            TW       = $clog2(LIMIT + 1);
   localparam logic [TW-1:0] LIMIT_V  = TW'(LIMIT);
   localparam logic [TW-1:0] LIMIT_M1 = TW'(LIMIT - 1);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_IDLE     = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_DRAIN    = 2'd3
   } state_t;

   logic [1:0]    rst_sync_r;
   logic          rst_n_s;
   state_t        state_r;
   state_t        state_s;
   logic          rx_en_r;
   logic          seen_wen_r;
   logic          fifo_wen_r;
   logic [7:0]    fifo_wdata_r;
   logic [15:0]   frame_cnt_r;
   logic          overrun_r;
   logic          frame_err_r;
   logic          irq_timeout_r;
   logic          irq_thresh_r;
   logic [TW-1:0] tick_cnt_r;
   logic          in_frame_s;
   logic          exit_s;
   logic          fe_set_s;
   logic          accept_s;
   logic          ov_set_s;
   logic          cnt_clr_s;
   logic          to_set_s;

   // Reset asserts immediately, releases two clocks after reset_n_i rises.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_r[1];

   // Next-state logic; a disable during a frame parks in DRAIN until the engine goes idle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_DISABLED: begin
            if (rx_enable_i) state_s = ST_IDLE;
            else             state_s = ST_DISABLED;
         end
         ST_IDLE: begin
            if (!rx_enable_i)    state_s = ST_DISABLED;
            else if (eng_busy_i) state_s = ST_ACTIVE;
            else                 state_s = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (!eng_busy_i)      state_s = ST_IDLE;
            else if (!rx_enable_i) state_s = ST_DRAIN;
            else                  state_s = ST_ACTIVE;
         end
         ST_DRAIN: begin
            if (!eng_busy_i) state_s = ST_DISABLED;
            else             state_s = ST_DRAIN;
         end
         default: state_s = ST_DISABLED;
      endcase
   end

   // Per-cycle event decode for forwarding, error flags and the idle-tick counter.
   always_comb begin
      in_frame_s = (state_r == ST_ACTIVE) || (state_r == ST_DRAIN);
      exit_s     = in_frame_s && !eng_busy_i;
      fe_set_s   = exit_s && !(seen_wen_r || eng_wen_i);
      accept_s   = eng_wen_i && !fifo_full_i;
      ov_set_s   = eng_wen_i && fifo_full_i;
      cnt_clr_s  = eng_busy_i || eng_wen_i || (fifo_count_i == {CW{1'b0}});
      to_set_s   = !cnt_clr_s && osr_tick_i && (tick_cnt_r == LIMIT_M1);
   end

   // State register, registered engine enable and per-episode byte-seen tracker.
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_r    <= ST_DISABLED;
         rx_en_r    <= 1'b0;
         seen_wen_r <= 1'b0;
      end else begin
         state_r <= state_s;
         rx_en_r <= (state_s != ST_DISABLED);
         if (exit_s || !in_frame_s) seen_wen_r <= 1'b0;
         else if (eng_wen_i)        seen_wen_r <= 1'b1;
         else                       seen_wen_r <= seen_wen_r;
      end
   end

   // FIFO write path and accepted-byte counter.
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         fifo_wen_r   <= 1'b0;
         fifo_wdata_r <= 8'h00;
         frame_cnt_r  <= 16'h0000;
      end else begin
         fifo_wen_r <= accept_s;
         if (accept_s) begin
            fifo_wdata_r <= eng_data_i;
            frame_cnt_r  <= frame_cnt_r + 16'd1;
         end else begin
            fifo_wdata_r <= fifo_wdata_r;
            frame_cnt_r  <= frame_cnt_r;
         end
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         overrun_r     <= 1'b0;
         frame_err_r   <= 1'b0;
         irq_timeout_r <= 1'b0;
      end else begin
         overrun_r     <= ov_set_s || (overrun_r && !err_clr_i);
         frame_err_r   <= fe_set_s || (frame_err_r && !err_clr_i);
         irq_timeout_r <= to_set_s || (irq_timeout_r && !timeout_clr_i);
      end
   end

   // Idle-tick counter saturates at the limit so the timeout fires once per idle period.
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         tick_cnt_r   <= {TW{1'b0}};
         irq_thresh_r <= 1'b0;
      end else begin
         if (cnt_clr_s)                                tick_cnt_r <= {TW{1'b0}};
         else if (osr_tick_i && tick_cnt_r != LIMIT_V) tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
         else                                          tick_cnt_r <= tick_cnt_r;
         irq_thresh_r <= (rx_thresh_i != {CW{1'b0}}) && (fifo_count_i >= rx_thresh_i);
      end
   end

   assign rx_en_o       = rx_en_r;
   assign fifo_wen_o    = fifo_wen_r;
   assign fifo_wdata_o  = fifo_wdata_r;
   assign frame_cnt_o   = frame_cnt_r;
   assign overrun_o     = overrun_r;
   assign frame_err_o   = frame_err_r;
   assign irq_timeout_o = irq_timeout_r;
   assign irq_thresh_o  = irq_thresh_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios with random bytes and gaps,
// compared every cycle against a behavioural model of the receive controller.
module tb_uart_rx_ctrl;

   localparam int CW    = 5;
   localparam int LIMIT = 4 * 10 * 16;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          rx_enable_i;
   logic          osr_tick_i;
   logic          rx_en_o;
   logic          eng_busy_i;
   logic          eng_wen_i;
   logic [7:0]    eng_data_i;
   logic          fifo_wen_o;
   logic [7:0]    fifo_wdata_o;
   logic          fifo_full_i;
   logic [CW-1:0] fifo_count_i;
   logic [CW-1:0] rx_thresh_i;
   logic          irq_thresh_o;
   logic          irq_timeout_o;
   logic          timeout_clr_i;
   logic          overrun_o;
   logic          frame_err_o;
   logic          err_clr_i;
   logic [15:0]   frame_cnt_o;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit          m_en, m_in_frame, m_drain, m_got;
   bit          m_fwen, m_ov, m_fe, m_to, m_th;
   logic [7:0]  m_wdata;
   logic [15:0] m_cnt;
   int          m_ticks;

   uart_rx_ctrl dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .rx_enable_i(rx_enable_i),
      .osr_tick_i(osr_tick_i), .rx_en_o(rx_en_o), .eng_busy_i(eng_busy_i),
      .eng_wen_i(eng_wen_i), .eng_data_i(eng_data_i), .fifo_wen_o(fifo_wen_o),
      .fifo_wdata_o(fifo_wdata_o), .fifo_full_i(fifo_full_i), .fifo_count_i(fifo_count_i),
      .rx_thresh_i(rx_thresh_i), .irq_thresh_o(irq_thresh_o), .irq_timeout_o(irq_timeout_o),
      .timeout_clr_i(timeout_clr_i), .overrun_o(overrun_o), .frame_err_o(frame_err_o),
      .err_clr_i(err_clr_i), .frame_cnt_o(frame_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_in_frame = 0; m_drain = 0; m_got = 0;
      m_fwen = 0; m_ov = 0; m_fe = 0; m_to = 0; m_th = 0;
      m_wdata = 8'h00; m_cnt = 16'h0000; m_ticks = 0;
   endtask

   task automatic check_all();
      chk("rx_en", rx_en_o, m_en);
      chk("fifo_wen", fifo_wen_o, m_fwen);
      if (m_fwen) chk("fifo_wdata", fifo_wdata_o, m_wdata);
      chk("overrun", overrun_o, m_ov);
      chk("frame_err", frame_err_o, m_fe);
      chk("irq_timeout", irq_timeout_o, m_to);
      chk("irq_thresh", irq_thresh_o, m_th);
      chk("frame_cnt", frame_cnt_o, m_cnt);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rx_en"}, rx_en_o, 0);
      chk({tag, "_fifo_wen"}, fifo_wen_o, 0);
      chk({tag, "_overrun"}, overrun_o, 0);
      chk({tag, "_frame_err"}, frame_err_o, 0);
      chk({tag, "_irq_timeout"}, irq_timeout_o, 0);
      chk({tag, "_irq_thresh"}, irq_thresh_o, 0);
      chk({tag, "_frame_cnt"}, frame_cnt_o, 0);
   endtask

   // Advance one clock: predict from the present inputs, then compare after the edge.
   task automatic step();
      bit set_ov, set_fe, set_to;
      int nt;
      m_fwen = eng_wen_i && !fifo_full_i;
      if (m_fwen) begin
         m_wdata = eng_data_i;
         m_cnt   = m_cnt + 16'd1;
      end
      set_ov = eng_wen_i && fifo_full_i;
      set_fe = 0;
      if (!m_en) begin
         if (rx_enable_i) m_en = 1;
      end else if (!m_in_frame) begin
         if (!rx_enable_i) m_en = 0;
         else if (eng_busy_i) begin m_in_frame = 1; m_got = 0; end
      end else if (!eng_busy_i) begin
         set_fe = !(m_got || eng_wen_i);
         m_in_frame = 0;
         if (m_drain) begin m_en = 0; m_drain = 0; end
      end else begin
         m_got = m_got || eng_wen_i;
         if (!rx_enable_i) m_drain = 1;
      end
      m_ov = set_ov || (m_ov && !err_clr_i);
      m_fe = set_fe || (m_fe && !err_clr_i);
      nt = (eng_busy_i || eng_wen_i || fifo_count_i == 0) ? 0 : m_ticks + int'(osr_tick_i);
      set_to = (nt == LIMIT) && (m_ticks == LIMIT - 1);
      m_ticks = nt;
      m_to = set_to || (m_to && !timeout_clr_i);
      m_th = (rx_thresh_i != 0) && (fifo_count_i >= rx_thresh_i);
      @(posedge clk_i);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      rx_enable_i = 0; osr_tick_i = 0; eng_busy_i = 0; eng_wen_i = 0; eng_data_i = 8'h00;
      fifo_full_i = 0; fifo_count_i = 0; rx_thresh_i = 0; timeout_clr_i = 0; err_clr_i = 0;
   endtask

   // Engine frame: busy for len cycles, byte pulse on the last busy cycle or on the exit cycle.
   task automatic frame(input logic [7:0] d, input int len, input bit wen_at_exit,
                        input bit no_wen, input bit full);
      eng_busy_i = 1;
      repeat (len - 1) begin
         osr_tick_i = 1'($urandom_range(0, 1));
         step();
      end
      eng_wen_i = !no_wen && !wen_at_exit;
      eng_data_i = d; fifo_full_i = full;
      step();
      eng_busy_i = 0;
      eng_wen_i = !no_wen && wen_at_exit;
      step();
      eng_wen_i = 0; fifo_full_i = 0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      reset_n_i = 0;
      repeat (3) @(posedge clk_i);
      #1;
      check_zero("reset");
      reset_n_i = 1;
      repeat (4) step();

      // single byte 0xA5 into an empty FIFO
      rx_enable_i = 1;
      step();
      chk("enable_rx_en", rx_en_o, 1);
      eng_busy_i = 1;
      repeat (4) step();
      eng_wen_i = 1; eng_data_i = 8'hA5;
      step();
      chk("a5_wen", fifo_wen_o, 1);
      chk("a5_wdata", fifo_wdata_o, 8'hA5);
      chk("a5_cnt", frame_cnt_o, 1);
      eng_wen_i = 0; eng_busy_i = 0;
      step();
      chk("a5_wen_drop", fifo_wen_o, 0);
      chk("a5_no_flags", {overrun_o, frame_err_o}, 0);

      // overrun, and set beating clear in the same cycle
      fifo_full_i = 1; eng_wen_i = 1; eng_data_i = 8'h3C;
      step();
      chk("ovr_no_write", fifo_wen_o, 0);
      chk("ovr_set", overrun_o, 1);
      err_clr_i = 1;
      step();
      chk("ovr_set_wins", overrun_o, 1);
      eng_wen_i = 0; fifo_full_i = 0;
      step();
      chk("ovr_cleared", overrun_o, 0);
      err_clr_i = 0;

      // false start, then bad stop
      frame(8'h00, 1, 0, 1, 0);
      chk("fe_false_start", frame_err_o, 1);
      err_clr_i = 1; step(); err_clr_i = 0;
      chk("fe_clr1", frame_err_o, 0);
      frame(8'h00, 6, 0, 1, 0);
      chk("fe_bad_stop", frame_err_o, 1);
      err_clr_i = 1; step(); err_clr_i = 0;
      chk("fe_clr2", frame_err_o, 0);

      // random traffic: bytes, lengths, full, exit-cycle bytes, gaps
      for (int i = 0; i < 24; i++) begin
         fifo_count_i = CW'($urandom_range(0, 8));
         frame(8'($urandom), $urandom_range(1, 9), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 3)) begin
            osr_tick_i = 1'($urandom_range(0, 1));
            err_clr_i = ($urandom_range(0, 5) == 0);
            step();
         end
         err_clr_i = 0;
      end
      osr_tick_i = 0; fifo_count_i = 0; err_clr_i = 1; timeout_clr_i = 1;
      step();
      err_clr_i = 0; timeout_clr_i = 0;

      // disable mid-frame: drain, ignored re-enable, byte still written
      eng_busy_i = 1;
      repeat (2) step();
      rx_enable_i = 0;
      step();
      chk("drain_rx_en", rx_en_o, 1);
      rx_enable_i = 1; step();
      rx_enable_i = 0; step();
      chk("drain_hold", rx_en_o, 1);
      eng_wen_i = 1; eng_data_i = 8'($urandom);
      step();
      chk("drain_write", fifo_wen_o, 1);
      eng_wen_i = 0; eng_busy_i = 0;
      step();
      chk("drain_off", rx_en_o, 0);
      rx_enable_i = 1;
      step();
      chk("reenable", rx_en_o, 1);

      // character timeout after exactly LIMIT ticks, no re-fire after clear
      fifo_count_i = 1; osr_tick_i = 1;
      repeat (LIMIT - 1) step();
      chk("to_before", irq_timeout_o, 0);
      step();
      chk("to_at_limit", irq_timeout_o, 1);
      repeat (10) step();
      timeout_clr_i = 1; step(); timeout_clr_i = 0;
      repeat (20) step();
      chk("to_no_refire", irq_timeout_o, 0);
      fifo_count_i = 0; step();
      fifo_count_i = 1;
      repeat (LIMIT - 40) step();
      eng_busy_i = 1; repeat (2) step();
      eng_busy_i = 0;
      repeat (100) step();
      chk("to_restart_no_irq", irq_timeout_o, 0);
      osr_tick_i = 0; fifo_count_i = 0;
      step();

      // threshold IRQ
      rx_thresh_i = 3;
      for (int c = 1; c <= 3; c++) begin
         fifo_count_i = CW'(c);
         step();
      end
      chk("thr_hit", irq_thresh_o, 1);
      fifo_count_i = 2; step();
      chk("thr_below", irq_thresh_o, 0);
      fifo_count_i = 3; rx_thresh_i = 0; step();
      chk("thr_disabled", irq_thresh_o, 0);

      // reset mid-frame with flags and counters non-zero
      rx_thresh_i = 1; fifo_full_i = 1; eng_wen_i = 1; step();
      fifo_full_i = 0; eng_wen_i = 0; eng_busy_i = 1;
      repeat (2) step();
      #2 reset_n_i = 0;
      #1 check_zero("midreset");
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk_i);
      #2 reset_n_i = 1;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
